// File: rtl/ldm_reg_writer_if.sv
// ldm_reg_writer_if: memory read bus between the load-multiple sequencer
// and the data memory. One request may be outstanding at a time.
//   mem_req   - read request, held until acknowledged (master -> slave)
//   mem_addr  - read address, stable while mem_req is high (master -> slave)
//   mem_ack   - read data valid / acknowledge (slave -> master)
//   mem_rdata - read data, qualified by mem_ack (slave -> master)
interface ldm_reg_writer_if #(
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/ldm_reg_writer.sv
// ldm_reg_writer: load-multiple write-back sequencer. Reads one memory word
// per set bit of reg_list (lowest register first, ascending addresses) and
// writes each word into the register file; r15 goes to the PC load path.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - begin transfer (sampled only in IDLE)
//   reg_list, base_addr - register bitmask and first address, latched on start
//   busy, done          - high outside IDLE / one-cycle completion pulse
//   mem                 - memory read bus (ldm_reg_writer_if master)
//   write_enable_ARd, Rd_Address, Rd_data - register-file write port
//   pc_load, pc_load_value                - PC load strobe and value
// Optional feature macro LDM_BASE_WRITEBACK_EN adds wb_en/base_reg and a WB
// state that writes base_addr + ADDR_STEP*N back to the base register.
module ldm_reg_writer #(
  parameter int unsigned ADDR_STEP = 4,
  parameter int          DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       reg_list,
  input  logic [31:0]       base_addr,
`ifdef LDM_BASE_WRITEBACK_EN
  input  logic              wb_en,
  input  logic [3:0]        base_reg,
`endif
  output logic              busy,
  output logic              done,
  ldm_reg_writer_if.master  mem,
  output logic              write_enable_ARd,
  output logic [3:0]        Rd_Address,
  output logic [DATA_W-1:0] Rd_data,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_load_value
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WRITE,
    S_DONE
`ifdef LDM_BASE_WRITEBACK_EN
    , S_WB
`endif
  } state_t;

  state_t            state, state_n;
  logic [15:0]       list_q, list_n;
  logic [31:0]       addr_q, addr_n;
  logic              req_q;
  logic [3:0]        target;
  logic              we_n, pcl_n;
  logic [3:0]        rda_n;
  logic [DATA_W-1:0] rdd_n, pcv_n;
`ifdef LDM_BASE_WRITEBACK_EN
  logic              wb_do_q, wb_do_n;
  logic [3:0]        base_reg_q, base_reg_n;
`endif

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;

  // Lowest set bit of the remaining list; descending scan so the last hit wins.
  always_comb begin
    target = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (list_q[4'(15 - i)]) target = 4'(15 - i);
    end
  end

  // Outputs are computed for the upcoming state and registered, so each
  // strobe is visible during the cycle its state is occupied.
  always_comb begin
    state_n = state;
    list_n  = list_q;
    addr_n  = addr_q;
    we_n    = 1'b0;
    pcl_n   = 1'b0;
    rda_n   = Rd_Address;
    rdd_n   = Rd_data;
    pcv_n   = pc_load_value;
`ifdef LDM_BASE_WRITEBACK_EN
    wb_do_n    = wb_do_q;
    base_reg_n = base_reg_q;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          if (reg_list != '0) begin
            list_n  = reg_list;
            addr_n  = base_addr;
            state_n = S_REQ;
`ifdef LDM_BASE_WRITEBACK_EN
            // A loaded base register keeps its loaded value.
            wb_do_n    = wb_en && !reg_list[base_reg];
            base_reg_n = base_reg;
`endif
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (mem.mem_ack) begin
          state_n = S_WRITE;
          if (target == 4'd15) begin
            pcl_n = 1'b1;
            pcv_n = mem.mem_rdata;
          end else begin
            we_n  = 1'b1;
            rda_n = target;
            rdd_n = mem.mem_rdata;
          end
        end
      end
      S_WRITE: begin
        list_n = list_q & (list_q - 16'd1);
        addr_n = addr_q + ADDR_STEP;
        if (list_n != '0) begin
          state_n = S_REQ;
        end else begin
          state_n = S_DONE;
`ifdef LDM_BASE_WRITEBACK_EN
          // After the last increment addr_n equals base_addr + ADDR_STEP*N.
          if (wb_do_q) begin
            state_n = S_WB;
            if (base_reg_q == 4'd15) begin
              pcl_n = 1'b1;
              pcv_n = DATA_W'(addr_n);
            end else begin
              we_n  = 1'b1;
              rda_n = base_reg_q;
              rdd_n = DATA_W'(addr_n);
            end
          end
`endif
        end
      end
`ifdef LDM_BASE_WRITEBACK_EN
      S_WB:    state_n = S_DONE;
`endif
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      list_q           <= '0;
      addr_q           <= '0;
      req_q            <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      write_enable_ARd <= 1'b0;
      Rd_Address       <= '0;
      Rd_data          <= '0;
      pc_load          <= 1'b0;
      pc_load_value    <= '0;
`ifdef LDM_BASE_WRITEBACK_EN
      wb_do_q          <= 1'b0;
      base_reg_q       <= '0;
`endif
    end else begin
      state            <= state_n;
      list_q           <= list_n;
      addr_q           <= addr_n;
      req_q            <= (state_n == S_REQ);
      busy             <= (state_n != S_IDLE);
      done             <= (state_n == S_DONE);
      write_enable_ARd <= we_n;
      Rd_Address       <= rda_n;
      Rd_data          <= rdd_n;
      pc_load          <= pcl_n;
      pc_load_value    <= pcv_n;
`ifdef LDM_BASE_WRITEBACK_EN
      wb_do_q          <= wb_do_n;
      base_reg_q       <= base_reg_n;
`endif
    end
  end

endmodule

// File: tb/tb_ldm_reg_writer.sv
// tb_ldm_reg_writer: directed self-checking bench for ldm_reg_writer.
// A bus responder returns addr ^ 0x5A5A0000 after a programmable ack delay;
// a monitor logs register writes, PC loads and done pulses relative to the
// cycle in which start was accepted.
module tb_ldm_reg_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] reg_list = '0;
  logic [31:0] base_addr = '0;
  logic        busy, done, write_enable_ARd, pc_load;
  logic [3:0]  Rd_Address;
  logic [31:0] Rd_data, pc_load_value;
`ifdef LDM_BASE_WRITEBACK_EN
  logic        wb_en = 1'b0;
  logic [3:0]  base_reg = '0;
`endif

  ldm_reg_writer_if #(.DATA_W(32)) bus ();

  ldm_reg_writer #(.ADDR_STEP(4), .DATA_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .reg_list         (reg_list),
    .base_addr        (base_addr),
`ifdef LDM_BASE_WRITEBACK_EN
    .wb_en            (wb_en),
    .base_reg         (base_reg),
`endif
    .busy             (busy),
    .done             (done),
    .mem              (bus),
    .write_enable_ARd (write_enable_ARd),
    .Rd_Address       (Rd_Address),
    .Rd_data          (Rd_data),
    .pc_load          (pc_load),
    .pc_load_value    (pc_load_value)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus responder
  int ack_delay = 0;
  int wcnt = 0;
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        if (wcnt == ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = bus.mem_addr ^ 32'h5A5A0000;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = 32'hDEADBEEF;
          wcnt++;
        end
      end else begin
        bus.mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor
  typedef struct {
    int          rel;
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t         wq[$];
  int          pq_rel[$];
  logic [31:0] pq_d[$];
  int          done_rel[$];
  int          ref_cyc = 0;
  int          req_cnt = 0;
  int          collide = 0;
  int          unstable = 0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (write_enable_ARd) wq.push_back('{cyc - ref_cyc, Rd_Address, Rd_data});
      if (pc_load) begin
        pq_rel.push_back(cyc - ref_cyc);
        pq_d.push_back(pc_load_value);
      end
      if (done) done_rel.push_back(cyc - ref_cyc);
      if (write_enable_ARd && pc_load) collide++;
      if (bus.mem_req && !prev_req) req_cnt++;
      if (bus.mem_req && prev_req && bus.mem_addr !== prev_addr) unstable++;
    end
    prev_req  = bus.mem_req;
    prev_addr = bus.mem_addr;
  end

  task automatic clear_logs();
    wq.delete();
    pq_rel.delete();
    pq_d.delete();
    done_rel.delete();
    req_cnt = 0;
  endtask

  // Returns at the negedge of relative cycle 1.
  task automatic run_start(input logic [15:0] l, input logic [31:0] b);
    clear_logs();
    @(negedge clk);
    reg_list  = l;
    base_addr = b;
    start     = 1'b1;
    ref_cyc   = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_rel.size() == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 32'(done_rel.size()), 32'd1);
    @(negedge clk);
    check("idle_after_done", {31'b0, busy}, 32'd0);
  endtask

  task automatic check_write(input int idx, input int rel, input logic [3:0] a, input logic [31:0] d);
    if (idx < wq.size()) begin
      check($sformatf("wr%0d_cycle", idx), 32'(wq[idx].rel), 32'(rel));
      check($sformatf("wr%0d_reg", idx), {28'b0, wq[idx].a}, {28'b0, a});
      check($sformatf("wr%0d_data", idx), wq[idx].d, d);
    end else begin
      check($sformatf("wr%0d_present", idx), 32'(wq.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_done_rel(input int rel);
    if (done_rel.size() > 0) check("done_cycle", 32'(done_rel[0]), 32'(rel));
    else check("done_cycle_present", 32'(done_rel.size()), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_req", {31'b0, bus.mem_req}, 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_we", {31'b0, write_enable_ARd}, 32'd0);
    check("rst_rd_data", Rd_data, 32'd0);
    check("rst_pc_load", {31'b0, pc_load}, 32'd0);
    check("rst_pc_value", pc_load_value, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three registers, same-cycle ack
    ack_delay = 0;
    run_start(16'h0013, 32'h100);
    wait_done(40);
    check("t1_nwrites", 32'(wq.size()), 32'd3);
    check_write(0, 2, 4'd0, 32'h5A5A0100);
    check_write(1, 4, 4'd1, 32'h5A5A0104);
    check_write(2, 6, 4'd4, 32'h5A5A0108);
    check_done_rel(7);

    // r15 goes to the PC path
    run_start(16'h8001, 32'h200);
    wait_done(40);
    check("t2_nwrites", 32'(wq.size()), 32'd1);
    check_write(0, 2, 4'd0, 32'h5A5A0200);
    check("t2_npc", 32'(pq_d.size()), 32'd1);
    if (pq_d.size() > 0) begin
      check("t2_pc_value", pq_d[0], 32'h5A5A0204);
      check("t2_pc_cycle", 32'(pq_rel[0]), 32'd4);
    end

    // Delayed ack: 4 REQ cycles + 1 WRITE per register
    ack_delay = 3;
    run_start(16'h0106, 32'h300);
    wait_done(100);
    check("t3_nwrites", 32'(wq.size()), 32'd3);
    check_write(0, 5, 4'd1, 32'h5A5A0300);
    check_write(1, 10, 4'd2, 32'h5A5A0304);
    check_write(2, 15, 4'd8, 32'h5A5A0308);
    check_done_rel(16);
    check("t3_nreq", 32'(req_cnt), 32'd3);
    ack_delay = 0;

    // Empty list
    run_start(16'h0000, 32'h700);
    wait_done(10);
    check_done_rel(1);
    check("t4_nwrites", 32'(wq.size()), 32'd0);
    check("t4_nreq", 32'(req_cnt), 32'd0);

    // Start while busy is ignored
    run_start(16'h0003, 32'h400);
    @(negedge clk);
    reg_list  = 16'hFFFF;
    base_addr = 32'h900;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(40);
    check("t5_nwrites", 32'(wq.size()), 32'd2);
    check_write(0, 2, 4'd0, 32'h5A5A0400);
    check_write(1, 4, 4'd1, 32'h5A5A0404);
    check_done_rel(5);

    // Address wrap
    run_start(16'h0003, 32'hFFFFFFFC);
    wait_done(40);
    check_write(0, 2, 4'd0, 32'hA5A5FFFC);
    check_write(1, 4, 4'd1, 32'h5A5A0000);

    // Reset during the second REQ of a four-register list
    run_start(16'h000F, 32'h500);
    repeat (2) @(negedge clk);
    check("t7_req_before_rst", {31'b0, bus.mem_req}, 32'd1);
    check("t7_addr_before_rst", bus.mem_addr, 32'h504);
    rst_n = 1'b0;
    #1;
    check("t7_busy_rst", {31'b0, busy}, 32'd0);
    check("t7_req_rst", {31'b0, bus.mem_req}, 32'd0);
    check("t7_addr_rst", bus.mem_addr, 32'd0);
    check("t7_we_rst", {31'b0, write_enable_ARd}, 32'd0);
    check("t7_rd_data_rst", Rd_data, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t7_nwrites", 32'(wq.size()), 32'd1);
    check("t7_no_done", 32'(done_rel.size()), 32'd0);
    run_start(16'h0001, 32'h600);
    wait_done(40);
    check_write(0, 2, 4'd0, 32'h5A5A0600);
    check_done_rel(3);

`ifdef LDM_BASE_WRITEBACK_EN
    // Base write-back
    wb_en    = 1'b1;
    base_reg = 4'd2;
    run_start(16'h0009, 32'h40);
    wait_done(40);
    check("wb_nwrites", 32'(wq.size()), 32'd3);
    check_write(0, 2, 4'd0, 32'h5A5A0040);
    check_write(1, 4, 4'd3, 32'h5A5A0044);
    check_write(2, 5, 4'd2, 32'h00000048);
    check_done_rel(6);
    run_start(16'h0004, 32'h80);
    wait_done(40);
    check("wb_skip_nwrites", 32'(wq.size()), 32'd1);
    check_write(0, 2, 4'd2, 32'h5A5A0080);
    wb_en = 1'b0;
`endif

    check("never_we_and_pc_load", 32'(collide), 32'd0);
    check("req_addr_stable", 32'(unstable), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
